// File: rtl/disk_loader_ctrl_pkg.sv
// disk_loader_ctrl_pkg: shared state/op encodings and disk range check
package disk_loader_ctrl_pkg;
  localparam int DEFAULT_DISK_WORDS = 1024;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;
  typedef enum logic {OP_LOAD = 1'b0, OP_STORE = 1'b1} op_t;
  // 33-bit sum so a base near 2^32 cannot wrap into range
  function automatic logic range_ok(input logic [31:0] base, input logic [15:0] len, input int words);
    return ({1'b0, base} + {17'd0, len}) <= 33'(words);
  endfunction
endpackage

// File: rtl/disk_loader_ctrl_if.sv
// disk_loader_ctrl_if: request, status, disk and memory signals of the loader
interface disk_loader_ctrl_if
  import disk_loader_ctrl_pkg::*;
#(
  parameter int MEM_AW = 10
);
  logic              start;
  op_t               op;
  logic [31:0]       disk_base;
  logic [MEM_AW-1:0] mem_base;
  logic [15:0]       length;
  logic              abort;
  logic              busy;
  logic              done;
  logic              error;
  logic              disk_we;
  logic [31:0]       disk_addr;
  logic [31:0]       disk_datain;
  logic [31:0]       disk_dataout;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  modport slave (
    input  start, op, disk_base, mem_base, length, abort, disk_dataout, mem_rdata,
    output busy, done, error, disk_we, disk_addr, disk_datain, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output start, op, disk_base, mem_base, length, abort, disk_dataout, mem_rdata,
    input  busy, done, error, disk_we, disk_addr, disk_datain, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/disk_loader_ctrl_xfer_counter.sv
// xfer_counter: word index of the active transfer with last-word detect
module xfer_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_inc,
  input  logic [15:0] i_length,
  output logic [15:0] o_idx,
  output logic        o_last
);
  logic [15:0] r_idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_idx <= '0;
    else r_idx <= i_clr ? '0 : i_inc ? r_idx + 16'd1 : r_idx;
  assign o_idx  = r_idx;
  assign o_last = r_idx == i_length - 16'd1;
endmodule

// File: rtl/disk_loader_ctrl.sv
// disk_loader_ctrl: block copy between disk and memory (LOAD disk->mem, STORE mem->disk),
// two cycles per word, with up-front range check and abort.
module disk_loader_ctrl
  import disk_loader_ctrl_pkg::*;
#(
  parameter int DISK_WORDS = DEFAULT_DISK_WORDS,
  parameter int MEM_AW     = 10
) (
  input logic               clk,
  input logic               rst_n,
  disk_loader_ctrl_if.slave bus
);
  state_t            r_state;
  op_t               r_op;
  logic [31:0]       r_disk_base;
  logic [MEM_AW-1:0] r_mem_base;
  logic [15:0]       r_length;
  logic              r_busy, r_done, r_error, r_disk_we, r_mem_we;
  logic [31:0]       r_disk_addr, r_disk_datain, r_mem_wdata;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [15:0]       w_idx, w_idx_nx;
  logic              w_last, w_clr, w_inc, w_range_ok;
  assign w_clr      = r_state == S_IDLE && bus.start;
  assign w_inc      = r_state == S_XFER && !bus.abort;
  assign w_idx_nx   = w_idx + 16'd1;
  assign w_range_ok = range_ok(bus.disk_base, bus.length, DISK_WORDS);
  xfer_counter u_cnt (
    .clk, .rst_n, .i_clr(w_clr), .i_inc(w_inc), .i_length(r_length), .o_idx(w_idx), .o_last(w_last)
  );
  // Outputs are registered on the edge entering a state, so the address for the
  // next ISSUE is formed from index+1 while the counter steps on that same edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= OP_LOAD;
      r_disk_base   <= '0;
      r_mem_base    <= '0;
      r_length      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_disk_we     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_disk_addr   <= '0;
      r_disk_datain <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_disk_we <= 1'b0;
      r_mem_we  <= 1'b0;
      if (r_busy && bus.abort) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_error <= 1'b1;
      end else
        case (r_state)
          S_IDLE:
            if (bus.start) begin
              r_op        <= bus.op;
              r_disk_base <= bus.disk_base;
              r_mem_base  <= bus.mem_base;
              r_length    <= bus.length;
              r_error     <= !w_range_ok;
              if (!w_range_ok || bus.length == 16'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_ISSUE;
                r_busy  <= 1'b1;
                if (bus.op == OP_LOAD) r_disk_addr <= bus.disk_base;
                else r_mem_addr <= bus.mem_base;
              end
            end
          S_ISSUE: begin
            r_state <= S_XFER;
            if (r_op == OP_LOAD) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_mem_base + MEM_AW'(w_idx);
              r_mem_wdata <= bus.disk_dataout;
            end else begin
              r_disk_we     <= 1'b1;
              r_disk_addr   <= r_disk_base + 32'(w_idx);
              r_disk_datain <= bus.mem_rdata;
            end
          end
          S_XFER:
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              if (r_op == OP_LOAD) r_disk_addr <= r_disk_base + 32'(w_idx_nx);
              else r_mem_addr <= r_mem_base + MEM_AW'(w_idx_nx);
            end
          default: r_state <= S_IDLE;
        endcase
    end
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.error       = r_error;
  assign bus.disk_we     = r_disk_we;
  assign bus.disk_addr   = r_disk_addr;
  assign bus.disk_datain = r_disk_datain;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
endmodule

// File: tb/tb_disk_loader_ctrl.sv
// tb_disk_loader_ctrl: directed and random transfers against disk/memory models and a
// word-level reference of what each request must leave behind.
module tb_disk_loader_ctrl;
  import disk_loader_ctrl_pkg::*;
  localparam int AW = 10;
  localparam int NW = 1024;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  disk_loader_ctrl_if #(.MEM_AW(AW)) bus ();
  disk_loader_ctrl #(.DISK_WORDS(NW), .MEM_AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [31:0] disk [NW];
  logic [31:0] mem [1 << AW];
  logic [31:0] exp_disk [NW];
  logic [31:0] exp_mem [1 << AW];
  int n_wr = 0;
  int vectors = 0;
  int errors = 0;
  bit overlap = 1'b0;

  // Disk and memory both return read data on the falling edge; writes land on the rising edge.
  always @(negedge clk) begin
    bus.disk_dataout <= bus.disk_addr < NW ? disk[bus.disk_addr[9:0]] : 32'hdead_beef;
    bus.mem_rdata    <= mem[bus.mem_addr];
    if (bus.disk_we && bus.mem_we) overlap <= 1'b1;
  end
  always @(posedge clk) begin
    if (bus.disk_we && bus.disk_addr < NW) disk[bus.disk_addr[9:0]] <= bus.disk_datain;
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.disk_we || bus.mem_we) n_wr <= n_wr + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no end, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic apply(input op_t o, input logic [31:0] db, input logic [AW-1:0] mb, input int words);
    for (int w = 0; w < words; w++) begin
      int m;
      m = (int'(mb) + w) % (1 << AW);
      if (o == OP_LOAD) exp_mem[m] = exp_disk[int'(db) + w];
      else exp_disk[int'(db) + w] = exp_mem[m];
    end
  endtask

  task automatic chk_image(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < NW; k++) if (disk[k] !== exp_disk[k] || mem[k] !== exp_mem[k]) bad++;
    chk({tag, " image"}, bad, 0);
  endtask

  // abort_k >= 0: abort on the edge that would start XFER of word abort_k;
  // abort_k == -2: abort raised together with start in IDLE (must be ignored).
  task automatic run(input op_t o, input logic [31:0] db, input logic [AW-1:0] mb,
                     input logic [15:0] len, input int abort_k, input bit spurious, input string tag);
    int words, exp_lat, lat, w0;
    bit exp_err, busy_bad;
    if (longint'(db) + longint'(len) > NW) begin
      words = 0; exp_err = 1'b1; exp_lat = 2;
    end else if (len == 16'd0) begin
      words = 0; exp_err = 1'b0; exp_lat = 2;
    end else if (abort_k >= 0 && abort_k < int'(len)) begin
      words = abort_k; exp_err = 1'b1; exp_lat = 2 * abort_k + 3;
    end else begin
      words = int'(len); exp_err = 1'b0; exp_lat = 2 * int'(len) + 2;
    end
    apply(o, db, mb, words);
    w0 = n_wr;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.disk_base = db; bus.mem_base = mb; bus.length = len;
    bus.abort = abort_k == -2;
    lat = 1;
    busy_bad = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      bus.start = spurious && lat == 3;
      if (bus.start) begin
        bus.op = OP_STORE; bus.disk_base = 0; bus.mem_base = 0; bus.length = 1;
      end
      bus.abort = abort_k >= 0 && lat == 2 + 2 * abort_k;
      if (!bus.done && !bus.busy) busy_bad = 1'b1;
    end while (!bus.done && lat < 2 * int'(len) + 10);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk({tag, " done"}, bus.done, 1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " error"}, bus.error, exp_err);
    chk({tag, " busy"}, {bus.busy, busy_bad}, 0);
    chk({tag, " writes"}, n_wr - w0, words);
    @(posedge clk); #1;
    chk({tag, " pulse"}, {bus.done, bus.busy, bus.error}, {2'b00, exp_err});
    chk_image(tag);
  endtask

  initial begin
    op_t r_o;
    logic [15:0] r_len;
    logic [31:0] r_db;
    logic [AW-1:0] r_mb;
    int r_ab, w0;
    bit saw_done;
    bus.start = 1'b0; bus.op = OP_LOAD; bus.disk_base = '0; bus.mem_base = '0;
    bus.length = '0; bus.abort = 1'b0;
    for (int k = 0; k < NW; k++) begin
      disk[k] = $urandom; mem[k] = $urandom;
    end
    disk[800] = 32'hA; disk[801] = 32'hB; disk[802] = 32'hC; disk[803] = 32'hD;
    mem[5] = 32'h11; mem[6] = 32'h22;
    for (int k = 0; k < NW; k++) begin
      exp_disk[k] = disk[k]; exp_mem[k] = mem[k];
    end
    #12;
    chk("reset flags", {bus.busy, bus.done, bus.error, bus.disk_we, bus.mem_we}, 0);
    chk("reset disk bus", {bus.disk_addr, bus.disk_datain}, 0);
    chk("reset mem bus", {bus.mem_addr, bus.mem_wdata}, 0);
    @(negedge clk) rst_n = 1'b1;
    run(OP_LOAD, 800, 0, 4, -1, 0, "load4");
    chk("load4 mem0", mem[0], 32'hA);
    chk("load4 mem3", mem[3], 32'hD);
    run(OP_STORE, 950, 5, 2, -1, 0, "store2");
    chk("store2 disk950", disk[950], 32'h11);
    chk("store2 disk951", disk[951], 32'h22);
    run(OP_LOAD, 1020, 0, 8, -1, 0, "range");
    run(OP_STORE, 32'hFFFF_FFF0, 0, 16'h20, -1, 0, "range33");
    run(OP_LOAD, 1016, 64, 8, -1, 0, "range_edge");
    run(OP_LOAD, 300, 40, 10, 2, 0, "abort");
    run(OP_STORE, 10, 10, 0, -1, 0, "len0");
    run(OP_LOAD, 500, 600, 3, -1, 1, "busy_start");
    run(OP_LOAD, 700, 10'(1023), 2, -1, 0, "wrap");
    run(OP_STORE, 400, 900, 3, -2, 0, "abort_with_start");
    run(OP_STORE, 410, 910, 3, 0, 0, "abort_first");
    // Reset during the ISSUE of the third word of a 5-word STORE: two words already written.
    apply(OP_STORE, 100, 200, 2);
    w0 = n_wr;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_STORE; bus.disk_base = 100; bus.mem_base = 200; bus.length = 5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst busy", {bus.busy, bus.done, bus.error}, 0);
    chk("rst we", {bus.disk_we, bus.mem_we}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("rst no done", saw_done, 0);
    chk("rst writes", n_wr - w0, 2);
    chk_image("rst");
    run(OP_STORE, 100, 200, 5, -1, 0, "after_rst");
    for (int t = 0; t < 16; t++) begin
      r_o = $urandom_range(0, 1) ? OP_STORE : OP_LOAD;
      r_len = 16'($urandom_range(0, 6));
      r_db = 32'($urandom_range(0, NW - 1));
      r_mb = AW'($urandom);
      r_ab = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 5)) : -1;
      run(r_o, r_db, r_mb, r_len, r_ab, $urandom_range(0, 1) == 1 && r_len != 0, "rand");
    end
    chk("we overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/disk_loader_ctrl.md
DISK_LOADER_CTRL -- requirements
Module: disk_loader_ctrl

Interface
REQ-001 SHALL have parameter DISK_WORDS, default 1024: number of addressable disk words.
REQ-002 SHALL have parameter MEM_AW, default 10: instruction/data memory word-address width.
REQ-003 SHALL have ports clk (input, 1, clock) and rst_n (input, 1, reset). There is one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start (input, 1): request a transfer; sampled only in IDLE.
REQ-005 SHALL have port op (input, 1): 0 = LOAD (disk->mem), 1 = STORE (mem->disk); sampled with start.
REQ-006 SHALL have port disk_base (input, 32): first disk word; sampled with start.
REQ-007 SHALL have port mem_base (input, MEM_AW): first memory word; sampled with start.
REQ-008 SHALL have port length (input, 16): word count; sampled with start.
REQ-009 SHALL have port abort (input, 1): terminate the active transfer.
REQ-010 SHALL have port busy (output, 1): transfer in progress.
REQ-011 SHALL have port done (output, 1): one-cycle completion pulse.
REQ-012 SHALL have port error (output, 1): last request rejected or aborted; held until next accepted start.
REQ-013 SHALL have disk-side ports disk_we (output, 1), disk_addr (output, 32), disk_datain (output, 32) and disk_dataout (input, 32).
REQ-014 SHALL have memory-side ports mem_we (output, 1), mem_addr (output, MEM_AW), mem_wdata (output, 32) and mem_rdata (input, 32; valid the cycle after mem_addr is presented).

Function
REQ-015 SHALL implement the states IDLE, ISSUE, XFER and DONE; all outputs SHALL be registered.
REQ-016 In IDLE with start=1, it SHALL latch op/disk_base/mem_base/length, clear the word index i and error, and check the range.
- disk_base+length > DISK_WORDS (33-bit compare): go to DONE with error=1; no disk or memory write occurs.
- length = 0: go to DONE with error=0.
- Otherwise: go to ISSUE.
REQ-017 In ISSUE, LOAD SHALL drive disk_addr = disk_base+i; STORE SHALL drive mem_addr = mem_base+i. The next state is XFER.
REQ-018 In XFER, LOAD SHALL assert mem_we for exactly one cycle with mem_addr = mem_base+i and mem_wdata = disk_dataout. The disk returns data on the falling edge of the ISSUE cycle.
REQ-019 In XFER, STORE SHALL assert disk_we for exactly one cycle with disk_addr = disk_base+i and disk_datain = mem_rdata.
REQ-020 After XFER, i SHALL increment. If i = length-1, the next state SHALL be DONE; otherwise it SHALL be ISSUE. Throughput is 2 cycles per word; total latency from start to done is 2*length+2 cycles.
REQ-021 mem_addr SHALL wrap modulo 2^MEM_AW. Disk addresses never wrap, because the range check of REQ-016 prevents it.
REQ-022 abort=1 in ISSUE or XFER SHALL go to DONE with error=1. It SHALL suppress any write in that cycle, and already-written words SHALL remain.
REQ-023 start while busy SHALL be ignored with no side effect. If abort and start arrive together in IDLE, abort SHALL be ignored and start SHALL be honoured.
REQ-024 In DONE, done SHALL be 1 for one cycle and busy SHALL be 0, then the state returns to IDLE. busy SHALL be 1 exactly in ISSUE and XFER.
REQ-025 disk_we and mem_we SHALL never be asserted in the same cycle, and never outside XFER.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE and i=0. It SHALL set busy, done, error, disk_we and mem_we to 0, and set disk_addr, disk_datain, mem_addr and mem_wdata to 0.
REQ-027 Reset mid-transfer SHALL abandon the transfer without a done pulse. No write SHALL occur on the edge that releases reset.

Structure
REQ-028 A shared package SHALL hold the state encoding, the op encoding (OP_LOAD = 0, OP_STORE = 1) and the default DISK_WORDS = 1024.
REQ-029 A single sub-module, xfer_counter, SHALL hold i with clear/increment/last-word compare; everything else stays flat.

Verification
REQ-030 LOAD: disk[800..803] = A,B,C,D; start, op=0, disk_base=800, mem_base=0, length=4 -> mem[0..3] = A..D, done at cycle 10, error=0.
REQ-031 STORE: mem[5..6] = 0x11, 0x22; op=1, disk_base=950, mem_base=5, length=2 -> disk[950] = 0x11, disk[951] = 0x22, done at cycle 6.
REQ-032 Range: disk_base=1020, length=8 -> done after 1 cycle, error=1, no disk_we or mem_we ever asserted.
REQ-033 Abort: LOAD of length=10, abort in the 3rd XFER -> exactly 2 mem writes, done pulse, error=1.
REQ-034 Reset: rst_n low during a STORE of length=5 -> busy=0 immediately, no done pulse; a new start afterwards completes normally.
REQ-035 Edges: length=0 -> done with error=0 and no writes; a second start while busy is ignored; mem_base = 2^MEM_AW-1 with length=2 -> wraps to mem word 0.
